// File: rtl/sha2_pkg.sv
// Shared types and constants for the multi-block SHA-2 round controller.
package sha2_pkg;

    // Controller phases for one message: setup, per-block work, completion.
    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT_BLK,
        LOAD,
        EXPAND,
        ROUND,
        UPDATE,
        FINISH
    } sha2_state_t;

    // Digest flavour latched at message start; it selects the IV set.
    localparam logic MODE_FULL  = 1'b0;
    localparam logic MODE_TRUNC = 1'b1;

    // Compression rounds per block for the two SHA-2 families.
    localparam int SHA256_ROUNDS = 64;
    localparam int SHA512_ROUNDS = 80;

endpackage

// File: rtl/sha2_multi_ctrl_if.sv
// Handshake and strobe bundle between a message source/datapath and the
// SHA-2 round controller. The controller sits on the slave side.
interface sha2_multi_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             start;
    logic             mode;
    logic             abort;
    logic             blk_valid;
    logic             blk_last;
    logic             blk_ready;
    logic             init_hash;
    logic             iv_sel;
    logic             load_msg;
    logic             expand_msg;
    logic             round_en;
    logic             update_hash;
    logic [CNT_W-1:0] round_no;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, abort, blk_valid, blk_last,
        input  blk_ready, init_hash, iv_sel, load_msg, expand_msg,
               round_en, update_hash, round_no, busy, done
    );

    modport slave (
        input  start, mode, abort, blk_valid, blk_last,
        output blk_ready, init_hash, iv_sel, load_msg, expand_msg,
               round_en, update_hash, round_no, busy, done
    );
endinterface

// File: rtl/sha2_round_cnt.sv
// Round index counter: cleared outside the round phase, advances by STEP
// per enabled cycle, and flags the last slice so the index never wraps.
module sha2_round_cnt #(
    parameter int NUM_ROUNDS = 64,
    parameter int STEP       = 1,
    parameter int CNT_W      = $clog2(NUM_ROUNDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             step_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ROUNDS - STEP);
    localparam logic [CNT_W-1:0] INC  = CNT_W'(STEP);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Terminal slice reached: the round phase ends after this cycle.
    assign tc_o    = (count_q == LAST);
    assign count_o = count_q;

    // Next index: restart at zero on clear or after the terminal slice.
    always_comb begin
        count_d = count_q;
        if (clear_i || (step_i && tc_o)) begin
            count_d = '0;
        end else if (step_i) begin
            count_d = count_q + INC;
        end
    end

    // Index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sha2_multi_ctrl.sv
// Multi-block SHA-2 compression controller: sequences IV load, block
// intake, message expansion, the round loop and hash update per block,
// and pulses done after the final block's update.
module sha2_multi_ctrl
    import sha2_pkg::*;
#(
    parameter int NUM_ROUNDS       = SHA256_ROUNDS,
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input logic               clk,
    input logic               rst,
    sha2_multi_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(NUM_ROUNDS);

    sha2_state_t      state_q;
    sha2_state_t      state_d;
    logic             start_prev_q;
    logic             iv_sel_q;
    logic             iv_sel_d;
    logic             last_q;
    logic             last_d;
    logic             start_pulse;
    logic             cnt_clear;
    logic             cnt_step;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_val;

    // start_prev_q resets high so a start held through reset is not an edge.
    assign start_pulse = bus.start & ~start_prev_q;

    // The round counter only runs in ROUND; an abort also clears it.
    assign cnt_step  = (state_q == ROUND);
    assign cnt_clear = (state_q != ROUND) || bus.abort;

    sha2_round_cnt #(
        .NUM_ROUNDS (NUM_ROUNDS),
        .STEP       (ROUNDS_PER_CYCLE),
        .CNT_W      (CNT_W)
    ) u_round_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cnt_clear),
        .step_i  (cnt_step),
        .count_o (cnt_val),
        .tc_o    (cnt_tc)
    );

    // Start edge detector history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_prev_q <= 1'b1;
        end else begin
            start_prev_q <= bus.start;
        end
    end

    // State and latched message flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            iv_sel_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            iv_sel_q <= iv_sel_d;
            last_q   <= last_d;
        end
    end

    // Next state: abort wins over everything, otherwise walk the block flow.
    always_comb begin
        state_d  = state_q;
        iv_sel_d = iv_sel_q;
        last_d   = last_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_pulse) begin
                        state_d  = INIT;
                        iv_sel_d = bus.mode;
                    end
                end
                INIT:     state_d = WAIT_BLK;
                WAIT_BLK: begin
                    if (bus.blk_valid) begin
                        state_d = LOAD;
                        last_d  = bus.blk_last;
                    end
                end
                LOAD:     state_d = EXPAND;
                EXPAND:   state_d = ROUND;
                ROUND: begin
                    if (cnt_tc) begin
                        state_d = UPDATE;
                    end
                end
                UPDATE:   state_d = last_q ? FINISH : WAIT_BLK;
                FINISH:   state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Moore decode of strobes from the registered state and counter.
    always_comb begin
        bus.blk_ready   = 1'b0;
        bus.init_hash   = 1'b0;
        bus.load_msg    = 1'b0;
        bus.expand_msg  = 1'b0;
        bus.round_en    = 1'b0;
        bus.update_hash = 1'b0;
        bus.done        = 1'b0;
        bus.round_no    = '0;
        bus.busy        = (state_q != IDLE);
        bus.iv_sel      = iv_sel_q;
        case (state_q)
            INIT:     bus.init_hash   = 1'b1;
            WAIT_BLK: bus.blk_ready   = 1'b1;
            LOAD:     bus.load_msg    = 1'b1;
            EXPAND:   bus.expand_msg  = 1'b1;
            ROUND: begin
                bus.round_en = 1'b1;
                bus.round_no = cnt_val;
            end
            UPDATE:   bus.update_hash = 1'b1;
            FINISH:   bus.done        = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_sha2_multi_ctrl.sv
// Self-checking bench for sha2_multi_ctrl: a default (64x1) and a wide
// (80x4) instance share stimulus; each scenario checks one of them against
// a per-cycle timeline of expected outputs built from the block flow.
module tb_sha2_multi_ctrl;
    import sha2_pkg::*;

    localparam int K_IDLE = 0;
    localparam int K_INIT = 1;
    localparam int K_WAIT = 2;
    localparam int K_LOAD = 3;
    localparam int K_EXP  = 4;
    localparam int K_RND  = 5;
    localparam int K_UPD  = 6;
    localparam int K_FIN  = 7;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic mode;
    logic abort;
    logic blk_valid;
    logic blk_last;
    bit   sel;

    int total = 0;
    int bad   = 0;
    int gap[3];

    logic [15:0] exp_q[$];
    bit          vld_q[$];
    bit          lst_q[$];
    bit          st_q[$];

    sha2_multi_ctrl_if #(.CNT_W(6)) b1 ();
    sha2_multi_ctrl_if #(.CNT_W(7)) b2 ();

    assign b1.start = start;  assign b2.start = start;
    assign b1.mode  = mode;   assign b2.mode  = mode;
    assign b1.abort = abort;  assign b2.abort = abort;
    assign b1.blk_valid = blk_valid;  assign b2.blk_valid = blk_valid;
    assign b1.blk_last  = blk_last;   assign b2.blk_last  = blk_last;

    sha2_multi_ctrl #(.NUM_ROUNDS(SHA256_ROUNDS), .ROUNDS_PER_CYCLE(1)) dut (
        .clk (clk), .rst (rst), .bus (b1.slave)
    );
    sha2_multi_ctrl #(.NUM_ROUNDS(SHA512_ROUNDS), .ROUNDS_PER_CYCLE(4)) dut_wide (
        .clk (clk), .rst (rst), .bus (b2.slave)
    );

    logic [15:0] obs1;
    logic [15:0] obs2;
    logic [15:0] obs;
    assign obs1 = {b1.init_hash, b1.blk_ready, b1.load_msg, b1.expand_msg, b1.round_en,
                   b1.update_hash, b1.done, b1.busy, b1.iv_sel, 1'b0, b1.round_no};
    assign obs2 = {b2.init_hash, b2.blk_ready, b2.load_msg, b2.expand_msg, b2.round_en,
                   b2.update_hash, b2.done, b2.busy, b2.iv_sel, b2.round_no};
    assign obs  = sel ? obs2 : obs1;

    always #5 clk = ~clk;

    // Expected output word for one cycle of a given phase.
    function automatic logic [15:0] ev(int k, int rno, bit ivs);
        logic [15:0] v;
        v      = '0;
        v[15]  = (k == K_INIT);
        v[14]  = (k == K_WAIT);
        v[13]  = (k == K_LOAD);
        v[12]  = (k == K_EXP);
        v[11]  = (k == K_RND);
        v[10]  = (k == K_UPD);
        v[9]   = (k == K_FIN);
        v[8]   = (k != K_IDLE);
        v[7]   = ivs;
        v[6:0] = 7'(rno);
        return v;
    endfunction

    task automatic push(int k, int rno, bit ivs, bit vld, bit lst);
        exp_q.push_back(ev(k, rno, ivs));
        vld_q.push_back(vld);
        lst_q.push_back(lst);
        st_q.push_back(1'($urandom_range(0, 1)));
    endtask

    // Timeline of a whole message: the first entry is the cycle after the
    // start edge. gap[b] idle WAIT cycles precede block b's acceptance.
    task automatic build(bit wide, int nblk, bit m, bit fin_pulse);
        int nr;
        int rpc;
        int n;
        nr  = wide ? SHA512_ROUNDS : SHA256_ROUNDS;
        rpc = wide ? 4 : 1;
        exp_q.delete(); vld_q.delete(); lst_q.delete(); st_q.delete();
        push(K_INIT, 0, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int b = 0; b < nblk; b++) begin
            for (int g = 0; g < gap[b]; g++) push(K_WAIT, 0, m, 1'b0, 1'($urandom_range(0, 1)));
            push(K_WAIT, 0, m, 1'b1, (b == nblk - 1));
            push(K_LOAD, 0, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            push(K_EXP, 0, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int k = 0; k < nr / rpc; k++)
                push(K_RND, k * rpc, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            push(K_UPD, 0, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        push(K_FIN, 0, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        push(K_IDLE, 0, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        n = exp_q.size();
        st_q[n-3] = 1'b0;
        st_q[n-2] = fin_pulse;
        st_q[n-1] = fin_pulse;
        if (fin_pulse) begin
            for (int i = 0; i < 3; i++) begin
                push(K_IDLE, 0, m, 1'b0, 1'b0);
                st_q[exp_q.size()-1] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_entry(int c);
        blk_valid = vld_q[c];
        blk_last  = lst_q[c];
        start     = st_q[c];
        mode      = 1'($urandom_range(0, 1));
    endtask

    // Return both instances to IDLE with start low for one edge.
    task automatic settle();
        abort = 1'b1; start = 1'b0; blk_valid = 1'b0; blk_last = 1'b0;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; mode = 1'b1; abort = 1'b0; blk_valid = 1'b1; blk_last = 1'b1;
        sel = 1'b0;
        #3;
        total++;
        if (obs1 !== 16'h0) begin bad++; $display("[TB] FAIL reset_std obs=%h exp=0000", obs1); end
        total++;
        if (obs2 !== 16'h0) begin bad++; $display("[TB] FAIL reset_wide obs=%h exp=0000", obs2); end
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (obs1 !== 16'h0) begin bad++; $display("[TB] FAIL start_thru_reset cyc=%0d obs=%h exp=0000", i, obs1); end
        end
    endtask

    task automatic test_single_block();
        settle();
        sel = 1'b0; gap[0] = 0;
        build(1'b0, 1, MODE_TRUNC, 1'b0);
        start = 1'b1; mode = MODE_TRUNC; blk_valid = 1'b1; blk_last = 1'b1;
        tick();
        for (int c = 0; c < exp_q.size(); c++) begin
            total++;
            if (obs !== exp_q[c]) begin bad++; $display("[TB] FAIL single cyc=%0d obs=%h exp=%h", c + 1, obs, exp_q[c]); end
            drive_entry(c);
            tick();
        end
    endtask

    task automatic test_wide_three();
        bit m;
        settle();
        sel = 1'b1; gap[0] = 0; gap[1] = 0; gap[2] = 0;
        m = 1'($urandom_range(0, 1));
        build(1'b1, 3, m, 1'b0);
        start = 1'b1; mode = m;
        tick();
        for (int c = 0; c < exp_q.size(); c++) begin
            total++;
            if (obs !== exp_q[c]) begin bad++; $display("[TB] FAIL wide3 cyc=%0d obs=%h exp=%h", c + 1, obs, exp_q[c]); end
            drive_entry(c);
            tick();
        end
    endtask

    task automatic test_wait_gap();
        settle();
        sel = 1'b0; gap[0] = 10; gap[1] = $urandom_range(1, 6);
        build(1'b0, 2, MODE_FULL, 1'b0);
        start = 1'b1; mode = MODE_FULL;
        tick();
        for (int c = 0; c < exp_q.size(); c++) begin
            total++;
            if (obs !== exp_q[c]) begin bad++; $display("[TB] FAIL wait_gap cyc=%0d obs=%h exp=%h", c + 1, obs, exp_q[c]); end
            drive_entry(c);
            tick();
        end
    endtask

    task automatic test_random();
        bit m;
        int nb;
        for (int t = 0; t < 4; t++) begin
            settle();
            sel = 1'($urandom_range(0, 1));
            nb  = $urandom_range(1, 3);
            for (int b = 0; b < 3; b++) gap[b] = $urandom_range(0, 4);
            m = 1'($urandom_range(0, 1));
            build(sel, nb, m, 1'($urandom_range(0, 1)));
            start = 1'b1; mode = m;
            tick();
            for (int c = 0; c < exp_q.size(); c++) begin
                total++;
                if (obs !== exp_q[c]) begin bad++; $display("[TB] FAIL random t=%0d cyc=%0d obs=%h exp=%h", t, c + 1, obs, exp_q[c]); end
                drive_entry(c);
                tick();
            end
        end
    endtask

    task automatic test_finish_start();
        settle();
        sel = 1'b0; gap[0] = 0;
        build(1'b0, 1, MODE_FULL, 1'b1);
        start = 1'b1; mode = MODE_FULL;
        tick();
        for (int c = 0; c < exp_q.size(); c++) begin
            total++;
            if (obs !== exp_q[c]) begin bad++; $display("[TB] FAIL finish_start cyc=%0d obs=%h exp=%h", c + 1, obs, exp_q[c]); end
            drive_entry(c);
            tick();
        end
    endtask

    task automatic test_abort();
        bit m;
        settle();
        sel = 1'b0; gap[0] = 0;
        m = 1'($urandom_range(0, 1));
        build(1'b0, 1, m, 1'b0);
        start = 1'b1; mode = m;
        tick();
        for (int c = 0; c < exp_q.size(); c++) begin
            total++;
            if (obs !== exp_q[c]) begin bad++; $display("[TB] FAIL abort_pre cyc=%0d obs=%h exp=%h", c + 1, obs, exp_q[c]); end
            drive_entry(c);
            if (c == 34) begin
                abort = 1'b1; start = 1'b0;
                tick();
                break;
            end
            tick();
        end
        abort = 1'b0;
        for (int i = 0; i < 40; i++) begin
            total++;
            if (obs !== ev(K_IDLE, 0, m)) begin bad++; $display("[TB] FAIL abort_idle cyc=%0d obs=%h exp=%h", i, obs, ev(K_IDLE, 0, m)); end
            blk_valid = 1'($urandom_range(0, 1));
            tick();
        end
        settle();
        gap[0] = $urandom_range(0, 3);
        build(1'b0, 1, ~m, 1'b0);
        start = 1'b1; mode = ~m;
        tick();
        for (int c = 0; c < exp_q.size(); c++) begin
            total++;
            if (obs !== exp_q[c]) begin bad++; $display("[TB] FAIL abort_rerun cyc=%0d obs=%h exp=%h", c + 1, obs, exp_q[c]); end
            drive_entry(c);
            tick();
        end
    endtask

    task automatic test_reset_mid();
        settle();
        sel = 1'b0; gap[0] = 0;
        build(1'b0, 1, MODE_TRUNC, 1'b0);
        start = 1'b1; mode = MODE_TRUNC;
        tick();
        for (int c = 0; c < exp_q.size(); c++) begin
            total++;
            if (obs !== exp_q[c]) begin bad++; $display("[TB] FAIL rst_pre cyc=%0d obs=%h exp=%h", c + 1, obs, exp_q[c]); end
            if (c == 14) break;
            drive_entry(c);
            tick();
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs1 !== 16'h0) begin bad++; $display("[TB] FAIL rst_async obs=%h exp=0000", obs1); end
        start = 1'b0;
        tick();
        total++;
        if (obs1 !== 16'h0) begin bad++; $display("[TB] FAIL rst_hold obs=%h exp=0000", obs1); end
        rst = 1'b0;
        settle();
        total++;
        if (obs1 !== 16'h0) begin bad++; $display("[TB] FAIL rst_after obs=%h exp=0000", obs1); end
        gap[0] = 0;
        build(1'b0, 1, MODE_FULL, 1'b0);
        start = 1'b1; mode = MODE_FULL;
        tick();
        for (int c = 0; c < exp_q.size(); c++) begin
            total++;
            if (obs !== exp_q[c]) begin bad++; $display("[TB] FAIL rst_rerun cyc=%0d obs=%h exp=%h", c + 1, obs, exp_q[c]); end
            drive_entry(c);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_wide_three();
        test_wait_gap();
        test_finish_start();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
